// File: rtl/mood_pkg.sv
// rtl/mood_pkg.sv - shared mood encodings and default timing constants for mood_trigger
package mood_pkg;

    // Must stay identical to animation_controller's IDLE/HAPPY encoding
    typedef enum logic {
        MOOD_IDLE  = 1'b0,
        MOOD_HAPPY = 1'b1
    } mood_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int DWELL_CYCLES_DEF    = 500_000_000;
    localparam int CNT_W_DEF           = 32;

endpackage

// File: rtl/mood_trigger_if.sv
// rtl/mood_trigger_if.sv - button input and go/mood/level outputs of mood_trigger
interface mood_trigger_if;
    logic btn_in;
    logic go;
    logic mood;
    logic btn_level;

    modport master (output btn_in, input go, input mood, input btn_level);
    modport slave  (input btn_in, output go, output mood, output btn_level);
endinterface

// File: rtl/mood_trigger_btn_debounce.sv
// rtl/mood_trigger_btn_debounce.sv - two-flop synchroniser, debounce counter and press strobe
import mood_pkg::*;

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;
    logic             w_accept;

    assign w_mismatch = (r_s2 != r_level);
    assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_s2;
                // Strobe only on the accepted rising level; releases are silent
                r_press <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/mood_trigger.sv
// rtl/mood_trigger.sv - debounced button to single-cycle go pulse with shadow mood FSM
// Optional auto-return to IDLE after the HAPPY dwell time: MOOD_AUTO_RETURN_EN
import mood_pkg::*;

module mood_trigger #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DWELL_CYCLES    = DWELL_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mood_trigger_if.slave  bus
);
    mood_t r_state;
    mood_t w_state_nxt;
    logic  r_go;
    logic  w_go_nxt;
    logic  w_press;
    logic  w_level;
    logic  w_expire;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.btn_in),
        .o_level (w_level),
        .o_press (w_press)
    );

`ifdef MOOD_AUTO_RETURN_EN
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] r_dwell;

    assign w_expire = (r_state == MOOD_HAPPY) && (r_dwell == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
        end else if (r_state == MOOD_IDLE && w_state_nxt == MOOD_HAPPY) begin
            r_dwell <= DWELL_LOAD;
        end else if (r_state == MOOD_HAPPY && r_dwell != '0) begin
            r_dwell <= r_dwell - 1'b1;
        end
    end
`else
    // Never true for a legal DWELL_CYCLES: HAPPY is left only by a press
    assign w_expire = (DWELL_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MOOD_IDLE;
            r_go    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_go    <= w_go_nxt;
        end
    end

    // A press landing right after a go is dropped so go never spans two cycles;
    // expiry and press together collapse into one toggle
    always_comb begin
        w_state_nxt = r_state;
        if (!r_go && (w_press || w_expire)) begin
            w_state_nxt = (r_state == MOOD_IDLE) ? MOOD_HAPPY : MOOD_IDLE;
        end
    end

    always_comb begin
        w_go_nxt = 1'b0;
        if (w_state_nxt != r_state) begin
            w_go_nxt = 1'b1;
        end
    end

    assign bus.go        = r_go;
    assign bus.mood      = r_state;
    assign bus.btn_level = w_level;

endmodule

// File: tb/tb_mood_trigger.sv
// tb/tb_mood_trigger.sv - randomized scoreboard bench for mood_trigger against a window-based reference model
module tb_mood_trigger;
    localparam int DEB   = 4;
    localparam int DWELL = 20;
`ifdef MOOD_AUTO_RETURN_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mood_trigger_if u_if ();

    mood_trigger #(
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_CYCLES    (DWELL),
        .CNT_W           (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct {
        int   edge_no;
        logic mood;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   edge_cnt = 0;

    bit m_s1, m_s2, m_level, m_press, m_go, m_mood;
    int m_enter;
    bit hist[$];

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, edge_cnt);
        end
    endtask

    // Reference: a level is accepted once the last DEB synchronised samples all disagree with it;
    // each accepted rise toggles mood one edge later, HAPPY expires DWELL edges after entry.
    task automatic model_step();
        bit fire;
        bit all_opp;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_go = 0; m_mood = 0; m_enter = 0;
            hist.delete();
            exp_q.delete();
        end else begin
            fire = !m_go && (m_press || (AUTO && m_mood && (edge_cnt - m_enter == DWELL)));
            m_go = fire;
            if (fire) begin
                m_mood = !m_mood;
                if (m_mood) m_enter = edge_cnt;
                exp_q.push_back('{edge_cnt, m_mood});
            end
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            all_opp = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] == m_level) all_opp = 0;
            m_press = 0;
            if (all_opp) begin
                m_level = !m_level;
                m_press = m_level;
            end
            m_s2 = m_s1;
            m_s1 = u_if.btn_in;
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_cnt++;
        model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        check("btn_level", int'(u_if.btn_level), int'(m_level));
        check("mood", int'(u_if.mood), int'(m_mood));
        if (u_if.go === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_go", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("go_edge", edge_cnt, e.edge_no);
                check("go_mood", int'(u_if.mood), int'(e.mood));
            end
        end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
            e = exp_q.pop_front();
            check("missed_go", 0, e.edge_no);
        end
    end

    task automatic drive(input bit v, input int n);
        u_if.btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check(name, int'({u_if.go, u_if.mood, u_if.btn_level}), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_go(output int e, output bit ok);
        ok = 0;
        e  = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (u_if.go === 1'b1) begin
                ok = 1;
                e  = edge_cnt;
            end
        end
        if (!ok) check("wait_go_timeout", 0, 1);
    endtask

    initial begin
        int e;
        bit ok;
        int gos;
        u_if.btn_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst_n = 1'b1;
        drive(0, 3);

        // Clean press, then bounce before a stable press
        drive(1, 12);
        drive(0, 12);
        drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1);
        drive(1, 12);
        drive(0, 12);

        // Press then idle long enough to see (or not) the auto-return
        do_reset();
        drive(0, 2);
        drive(1, 12);
        drive(0, 40);

        // Second press lands its go exactly on the dwell expiry edge
        do_reset();
        u_if.btn_in = 1'b1;
        wait_go(e, ok);
        if (ok) begin
            u_if.btn_in = 1'b0;
            while (edge_cnt < e + 13) @(negedge clk);
            u_if.btn_in = 1'b1;
            gos = 0;
            while (edge_cnt < e + 25) begin
                @(negedge clk);
                if (u_if.go === 1'b1) gos++;
            end
            check("collision_single_go", gos, 1);
            check("collision_mood_idle", int'(u_if.mood), 0);
        end
        drive(0, 12);

        // Random bouncing
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
        end
        drive(0, 12);

        // Asynchronous reset mid-dwell with the button held
        do_reset();
        u_if.btn_in = 1'b1;
        wait_go(e, ok);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gos = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_if.go === 1'b1) gos++;
        end
        check("post_reset_single_go", gos, 1);
        drive(0, 30);

        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
